mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Two-port round-robin arbiter sharing the single burst memory port between requesters
//  (port 0: write DMA filling the frame buffer; port 1: scanout read DMA).
//  Forwards one whole burst (request phase + len+1 data beats) per grant, then re-arbitrates.
//  Sits between the DMA engines and the memory controller.
// PARAMETERS
//  AW  23  word-address width
//  DW  32  data width
// PORTS
//  clk         in   1   system clock; all logic on rising edge
//  rstn        in   1   reset, asynchronous, active-low
//  pN_addr     in   AW  burst start address, port N (N=0,1); valid while pN_req
//  pN_len      in   2   beats-1 (3 = 4-beat burst)
//  pN_wr       in   1   1=write burst, 0=read burst
//  pN_req      in   1   burst request; held until pN_ready
//  pN_ready    out  1   request accepted (1-cycle pulse)
//  pN_ack      out  1   data-beat strobe
//  pN_wdata    in   DW  write data for the current beat; sampled by memory on pN_ack
//  pN_rdata    out  DW  read data; valid when pN_ack && !pN_wr
//  mem_addr    out  AW  to controller: muxed from the granted port
//  mem_len     out  2   muxed pN_len
//  mem_wr      out  1   muxed pN_wr
//  mem_wdata   out  DW  muxed pN_wdata
//  mem_req     out  1   request to the memory controller
//  mem_ready   in   1   controller accepted request
//  mem_ack     in   1   controller beat strobe
//  mem_rdata   in   DW  read data from the controller
//  gnt         out  2   one-hot current grant (debug); 0 in IDLE
// BEHAVIOUR
//  States: IDLE, REQ, DAT. Registers: state, gsel (granted port), last (last winner), beats[1:0].
//  Reset: state=IDLE, gsel=0, last=1 (port 0 wins first tie), beats=0.
//   Outputs at reset: mem_req=0, pN_ready=0, pN_ack=0, gnt=0.
//  IDLE: if any pN_req, pick a winner -> gsel, go REQ next cycle (1 cycle arbitration latency).
//   Only one requesting -> it wins. Both requesting -> the port != last wins.
//  REQ: mem_req=1; mem_addr/len/wr = granted port's inputs (combinational mux).
//   mem_ready: pulse pN_ready of granted port same cycle; beats<=mem_len; last<=gsel; go DAT.
//   Granted pN_req drops before mem_ready: mem_req drops the same cycle (combinational);
//   return to IDLE, last unchanged.
//   mem_ready && mem_ack in the same cycle: that ack is beat 0 (forwarded, counted);
//   if mem_len==0, go IDLE instead of DAT.
//  DAT: mem_req=0. Each mem_ack -> pN_ack of granted port same cycle; beats decrements.
//   Ack with beats==0 is the last beat: go IDLE next cycle.
//  Forwarding: pN_ack, pN_ready, pN_rdata (=mem_rdata) pass combinationally; zero latency.
//   The non-granted port always sees ready=0, ack=0. mem_wdata = granted pN_wdata.
//   Requesters present the next word the cycle after each ack.
//  Ignored: mem_ready outside REQ; mem_ack in IDLE. Never forwarded, no state change.
//  Burst length is latched at mem_ready; later pN_len changes have no effect.
//  No pre-emption: a burst always completes before re-arbitration.
//  Fairness: back-to-back requesters alternate; turnaround is 1 IDLE cycle between bursts.
//  rstn asserted mid-burst: immediate return to reset state; the partial burst is abandoned
//   and the memory controller is reset with the same rstn.
//  gnt = one-hot(gsel) in REQ and DAT, else 0.
// TESTING
//  1. p0_req only, addr=0x100, len=3, wr=1; ready after 2 cyc, 4 acks -> mem_addr=0x100,
//     p0_ready 1 pulse, 4 p0_ack, mem_wdata tracks p0_wdata; p1_ack stays 0; IDLE after.
//  2. p0_req and p1_req in same cycle after reset -> port 0 served first, then port 1
//     (1 IDLE cycle gap); repeat with both held -> grants alternate 0,1,0,1.
//  3. p1 read, len=1, mem_rdata=0xDEADBEEF,0x12345678 -> p1_rdata shows both on p1_ack;
//     p0_ack stays 0.
//  4. mem_ready and mem_ack in same cycle, len=0 -> 1 ready + 1 ack; back to IDLE next cycle.
//  5. Spurious mem_ack in IDLE and mem_ready in DAT -> no pN_ack/pN_ready; beat count unchanged.
//  6. rstn low during beat 2 of a 4-beat burst -> mem_req=0, gnt=0 immediately; first grant
//     after release goes to port 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter forwarding whole bursts to one memory port
module mem_arbiter #(
    parameter int AW = 23,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [AW-1:0] p0_addr,
    input  logic [1:0]    p0_len,
    input  logic          p0_wr,
    input  logic          p0_req,
    output logic          p0_ready,
    output logic          p0_ack,
    input  logic [DW-1:0] p0_wdata,
    output logic [DW-1:0] p0_rdata,
    input  logic [AW-1:0] p1_addr,
    input  logic [1:0]    p1_len,
    input  logic          p1_wr,
    input  logic          p1_req,
    output logic          p1_ready,
    output logic          p1_ack,
    input  logic [DW-1:0] p1_wdata,
    output logic [DW-1:0] p1_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [1:0]    mem_len,
    output logic          mem_wr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_req,
    input  logic          mem_ready,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    gnt
);
    typedef enum logic [1:0] {IDLE, REQ, DAT} state_t;
    state_t state, state_n;
    logic gsel, gsel_n, last;
    logic [1:0] beats;
    logic req_g, rdy, ack;
    assign req_g     = gsel ? p1_req : p0_req;
    assign mem_addr  = gsel ? p1_addr : p0_addr;
    assign mem_len   = gsel ? p1_len : p0_len;
    assign mem_wr    = gsel ? p1_wr : p0_wr;
    assign mem_wdata = gsel ? p1_wdata : p0_wdata;
    assign mem_req   = (state == REQ) && req_g;
    assign rdy       = mem_req && mem_ready;
    assign ack       = (state == DAT || rdy) && mem_ack;
    assign p0_ready  = rdy && !gsel;
    assign p1_ready  = rdy && gsel;
    assign p0_ack    = ack && !gsel;
    assign p1_ack    = ack && gsel;
    assign p0_rdata  = mem_rdata;
    assign p1_rdata  = mem_rdata;
    assign gnt       = (state == IDLE) ? 2'b00 : {gsel, !gsel};
    // next-state and winner selection; a tie goes to the port that did not win last
    always_comb begin
        state_n = state;
        gsel_n  = gsel;
        case (state)
            IDLE: if (p0_req || p1_req) begin
                gsel_n  = (p0_req && p1_req) ? !last : p1_req;
                state_n = REQ;
            end
            REQ: if (!req_g) state_n = IDLE;
                 else if (mem_ready) state_n = (mem_ack && mem_len == 2'd0) ? IDLE : DAT;
            DAT: if (mem_ack && beats == 2'd0) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    // state and grant registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            gsel  <= 1'b0;
        end else begin
            state <= state_n;
            gsel  <= gsel_n;
        end
    end
    // burst length latched at acceptance, counted down per beat; last winner recorded
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last  <= 1'b1;
            beats <= 2'd0;
        end else if (rdy) begin
            last  <= gsel;
            beats <= mem_ack ? mem_len - 2'd1 : mem_len;
        end else if (state == DAT && mem_ack) begin
            beats <= beats - 2'd1;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed-vector bench for mem_arbiter
module tb_mem_arbiter;
    logic        clk = 0, rstn = 0;
    logic [22:0] p0_addr = 0, p1_addr = 0, mem_addr;
    logic [1:0]  p0_len = 0, p1_len = 0, mem_len, gnt;
    logic        p0_wr = 0, p1_wr = 0, p0_req = 0, p1_req = 0;
    logic        p0_ready, p1_ready, p0_ack, p1_ack, mem_wr, mem_req;
    logic        mem_ready = 0, mem_ack = 0;
    logic [31:0] p0_wdata = 0, p1_wdata = 0, p0_rdata, p1_rdata, mem_wdata, mem_rdata = 0;
    int nvec = 0, nerr = 0;

    mem_arbiter #(.AW(23), .DW(32)) dut (
        .clk(clk), .rstn(rstn),
        .p0_addr(p0_addr), .p0_len(p0_len), .p0_wr(p0_wr), .p0_req(p0_req),
        .p0_ready(p0_ready), .p0_ack(p0_ack), .p0_wdata(p0_wdata), .p0_rdata(p0_rdata),
        .p1_addr(p1_addr), .p1_len(p1_len), .p1_wr(p1_wr), .p1_req(p1_req),
        .p1_ready(p1_ready), .p1_ack(p1_ack), .p1_wdata(p1_wdata), .p1_rdata(p1_rdata),
        .mem_addr(mem_addr), .mem_len(mem_len), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_req(mem_req), .mem_ready(mem_ready), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .gnt(gnt)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset;
        rstn = 0;
        tick();
        #1;
        nvec++; if ({mem_req, gnt} !== 3'b000) begin nerr++; $display("FAIL reset_out: mem_req/gnt=%b want 000", {mem_req, gnt}); end
        nvec++; if ({p0_ready, p1_ready, p0_ack, p1_ack} !== 4'b0) begin nerr++; $display("FAIL reset_hs: rdy/ack=%b want 0000", {p0_ready, p1_ready, p0_ack, p1_ack}); end
        rstn = 1;
        tick();
    endtask

    task automatic test_single_write;
        p0_req = 1; p0_addr = 23'h100; p0_len = 3; p0_wr = 1; p0_wdata = 32'hA0;
        #1;
        nvec++; if ({mem_req, gnt} !== 3'b000) begin nerr++; $display("FAIL w_idle: mem_req/gnt=%b want 000", {mem_req, gnt}); end
        tick();
        nvec++; if ({mem_req, gnt, p0_ready} !== 4'b1010) begin nerr++; $display("FAIL w_req: mem_req/gnt/rdy=%b want 1010", {mem_req, gnt, p0_ready}); end
        nvec++; if (mem_addr !== 23'h100) begin nerr++; $display("FAIL w_addr: got %h want 100", mem_addr); end
        tick();
        mem_ready = 1;
        #1;
        nvec++; if ({p0_ready, p1_ready, mem_len, mem_wr} !== 5'b10111) begin nerr++; $display("FAIL w_ready: got %b want 10111", {p0_ready, p1_ready, mem_len, mem_wr}); end
        tick();
        mem_ready = 0; p0_req = 0;
        #1;
        nvec++; if ({mem_req, p0_ready} !== 2'b00) begin nerr++; $display("FAIL w_dat: mem_req/rdy=%b want 00", {mem_req, p0_ready}); end
        for (int i = 0; i < 4; i++) begin
            mem_ack = 1; p0_wdata = 32'hA0 + i;
            #1;
            nvec++; if ({p0_ack, p1_ack, gnt} !== 4'b1001) begin nerr++; $display("FAIL w_beat%0d: ack0/ack1/gnt=%b want 1001", i, {p0_ack, p1_ack, gnt}); end
            nvec++; if (mem_wdata !== 32'hA0 + i) begin nerr++; $display("FAIL w_wdata%0d: got %h want %h", i, mem_wdata, 32'hA0 + i); end
            tick();
        end
        mem_ack = 0;
        #1;
        nvec++; if (gnt !== 2'b00) begin nerr++; $display("FAIL w_end: gnt=%b want 00", gnt); end
    endtask

    task automatic test_round_robin;
        logic [1:0] exp;
        test_reset();
        p0_len = 0; p1_len = 0; p0_req = 1; p1_req = 1;
        tick();
        for (int k = 0; k < 4; k++) begin
            exp = (k % 2 == 0) ? 2'b01 : 2'b10;
            nvec++; if (gnt !== exp) begin nerr++; $display("FAIL rr_gnt%0d: gnt=%b want %b", k, gnt, exp); end
            mem_ready = 1; mem_ack = 1;
            #1;
            nvec++; if ({p1_ready, p0_ready, p1_ack, p0_ack} !== {exp, exp}) begin nerr++; $display("FAIL rr_hs%0d: got %b want %b", k, {p1_ready, p0_ready, p1_ack, p0_ack}, {exp, exp}); end
            tick();
            mem_ready = 0; mem_ack = 0;
            #1;
            nvec++; if (gnt !== 2'b00) begin nerr++; $display("FAIL rr_gap%0d: gnt=%b want 00", k, gnt); end
            tick();
        end
        p0_req = 0; p1_req = 0;
        #1;
        nvec++; if (mem_req !== 1'b0) begin nerr++; $display("FAIL rr_drop: mem_req=%b want 0", mem_req); end
        tick();
        nvec++; if (gnt !== 2'b00) begin nerr++; $display("FAIL rr_idle: gnt=%b want 00", gnt); end
    endtask

    task automatic test_read;
        p1_req = 1; p1_wr = 0; p1_len = 1; p1_addr = 23'h2000;
        tick();
        nvec++; if (gnt !== 2'b10) begin nerr++; $display("FAIL rd_gnt: gnt=%b want 10", gnt); end
        mem_ready = 1;
        #1;
        nvec++; if ({p1_ready, p0_ready, mem_wr} !== 3'b100 || mem_addr !== 23'h2000) begin nerr++; $display("FAIL rd_req: rdy/wr=%b addr=%h want 100 2000", {p1_ready, p0_ready, mem_wr}, mem_addr); end
        tick();
        mem_ready = 0; p1_req = 0; mem_ack = 1; mem_rdata = 32'hDEADBEEF;
        #1;
        nvec++; if ({p1_ack, p0_ack} !== 2'b10 || p1_rdata !== 32'hDEADBEEF) begin nerr++; $display("FAIL rd_beat0: ack=%b data=%h want 10 deadbeef", {p1_ack, p0_ack}, p1_rdata); end
        tick();
        mem_rdata = 32'h12345678;
        #1;
        nvec++; if ({p1_ack, p0_ack} !== 2'b10 || p1_rdata !== 32'h12345678) begin nerr++; $display("FAIL rd_beat1: ack=%b data=%h want 10 12345678", {p1_ack, p0_ack}, p1_rdata); end
        tick();
        mem_ack = 0;
        #1;
        nvec++; if (gnt !== 2'b00) begin nerr++; $display("FAIL rd_end: gnt=%b want 00", gnt); end
    endtask

    task automatic test_ready_ack_same;
        p0_req = 1; p0_len = 0; p0_wr = 1;
        tick();
        mem_ready = 1; mem_ack = 1;
        #1;
        nvec++; if ({p0_ready, p0_ack, p1_ready, p1_ack} !== 4'b1100) begin nerr++; $display("FAIL ra_same: got %b want 1100", {p0_ready, p0_ack, p1_ready, p1_ack}); end
        tick();
        mem_ready = 0; mem_ack = 0; p0_req = 0;
        #1;
        nvec++; if (gnt !== 2'b00) begin nerr++; $display("FAIL ra_idle: gnt=%b want 00", gnt); end
    endtask

    task automatic test_spurious;
        mem_ack = 1; mem_ready = 1;
        #1;
        nvec++; if ({p0_ready, p1_ready, p0_ack, p1_ack} !== 4'b0) begin nerr++; $display("FAIL sp_idle: got %b want 0000", {p0_ready, p1_ready, p0_ack, p1_ack}); end
        tick();
        mem_ack = 0; mem_ready = 0;
        #1;
        nvec++; if (gnt !== 2'b00) begin nerr++; $display("FAIL sp_state: gnt=%b want 00", gnt); end
        p0_req = 1; p0_len = 3;
        tick();
        mem_ready = 1;
        tick();
        mem_ready = 0; p0_req = 0; mem_ack = 1;
        tick();
        mem_ack = 0; mem_ready = 1;
        #1;
        nvec++; if ({p0_ready, p0_ack, p1_ready, p1_ack} !== 4'b0) begin nerr++; $display("FAIL sp_dat: got %b want 0000", {p0_ready, p0_ack, p1_ready, p1_ack}); end
        tick();
        mem_ready = 0; mem_ack = 1;
        tick();
        tick();
        #1;
        nvec++; if ({gnt, p0_ack} !== 3'b011) begin nerr++; $display("FAIL sp_last: gnt/ack=%b want 011", {gnt, p0_ack}); end
        tick();
        mem_ack = 0;
        #1;
        nvec++; if (gnt !== 2'b00) begin nerr++; $display("FAIL sp_end: gnt=%b want 00", gnt); end
    endtask

    task automatic test_reset_mid_burst;
        p0_req = 1; p0_len = 3;
        tick();
        mem_ready = 1;
        tick();
        mem_ready = 0; p0_req = 0; mem_ack = 1;
        tick();
        #1;
        nvec++; if ({p0_ack, gnt} !== 3'b101) begin nerr++; $display("FAIL mr_beat: ack/gnt=%b want 101", {p0_ack, gnt}); end
        rstn = 0;
        #1;
        nvec++; if ({mem_req, gnt, p0_ack, p1_ack} !== 5'b0) begin nerr++; $display("FAIL mr_async: got %b want 00000", {mem_req, gnt, p0_ack, p1_ack}); end
        tick();
        mem_ack = 0; rstn = 1; p0_req = 1; p1_req = 1; p0_len = 0; p1_len = 0;
        tick();
        nvec++; if (gnt !== 2'b01) begin nerr++; $display("FAIL mr_first: gnt=%b want 01", gnt); end
        mem_ready = 1; mem_ack = 1;
        tick();
        mem_ready = 0; mem_ack = 0; p0_req = 0; p1_req = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_read();
        test_ready_ack_same();
        test_spurious();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end
endmodule
